// File: rtl/wall_map_receiver.sv
// Wall-map receiver: synchronised SoC PIO writes, hardware clear sweep and a registered renderer read port.
// Optional WALL_MAP_ECHO_EN adds echo_data, a second registered read port addressed by walls_addr.
module wall_map_receiver #(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       DATA_W      = 8,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] CLEAR_VAL   = '0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] walls_addr,
    input  logic [DATA_W-1:0] walls_data,
    input  logic              walls_we,
    input  logic              clear_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              screen_reset
`ifdef WALL_MAP_ECHO_EN
    ,
    output logic [DATA_W-1:0] echo_data
`endif
);

    localparam int unsigned       DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR, DONE} state_t;

    state_t                 state;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [SYNC_STAGES-1:0] we_sync;
    logic                   we_prev;
    logic                   pending;
    logic [ADDR_W-1:0]      paddr;
    logic [DATA_W-1:0]      pdata;
    logic [ADDR_W-1:0]      clr_ptr;
    logic                   clr_pend;

    logic                   we_edge_c;
    logic                   go_clear_c;
    logic                   go_write_c;
    logic                   mem_we_c;
    logic [ADDR_W-1:0]      mem_wa_c;
    logic [DATA_W-1:0]      mem_wd_c;

    assign we_edge_c  = we_sync[SYNC_STAGES-1] & ~we_prev;
    assign go_clear_c = (state == IDLE) & (clear_req | clr_pend);
    // A write edge seen in IDLE is captured and serviced on the very next cycle.
    assign go_write_c = (state == IDLE) & ~go_clear_c & (pending | we_edge_c);

    assign mem_we_c = (state == WRITE) | (state == CLEAR);
    assign mem_wa_c = (state == CLEAR) ? clr_ptr : paddr;
    assign mem_wd_c = (state == CLEAR) ? CLEAR_VAL : pdata;

    // Strobe synchroniser and rising-edge history.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            we_sync <= '0;
            we_prev <= 1'b0;
        end else begin
            we_sync <= {we_sync[SYNC_STAGES-2:0], walls_we};
            we_prev <= we_sync[SYNC_STAGES-1];
        end
    end

    // Single-entry pending buffer; a newer edge overwrites an unserviced write.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pending <= 1'b0;
            paddr   <= '0;
            pdata   <= '0;
        end else if (we_edge_c) begin
            pending <= 1'b1;
            paddr   <= walls_addr;
            pdata   <= walls_data;
        end else if (state == WRITE) begin
            pending <= 1'b0;
        end
    end

    // Control FSM; busy and screen_reset are registered from the next-state view.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= IDLE;
            clr_ptr      <= '0;
            clr_pend     <= 1'b0;
            busy         <= 1'b0;
            screen_reset <= 1'b0;
        end else begin
            busy         <= (state == CLEAR) | go_clear_c | go_write_c | we_edge_c
                            | (pending & (state != WRITE));
            screen_reset <= go_clear_c | ((state == CLEAR) & (clr_ptr != PTR_LAST));
            case (state)
                IDLE: begin
                    if (go_clear_c) begin
                        state    <= CLEAR;
                        clr_ptr  <= '0;
                        clr_pend <= 1'b0;
                    end else if (go_write_c) begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                    if (clear_req) clr_pend <= 1'b1;
                end
                CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_W'(1);
                    if (clr_ptr == PTR_LAST) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                    if (clear_req) clr_pend <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Single write port shared by the write path and the clear sweep.
    always_ff @(posedge Clk) begin
        if (mem_we_c) mem[mem_wa_c] <= mem_wd_c;
    end

    // Renderer port masks the half-cleared map for the whole sweep.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_data <= '0;
        end else if ((state == CLEAR) | go_clear_c) begin
            rd_data <= CLEAR_VAL;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

`ifdef WALL_MAP_ECHO_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) echo_data <= '0;
        else       echo_data <= mem[walls_addr];
    end
`endif

endmodule

// File: tb/tb_wall_map_receiver.sv
// Randomised self-checking bench for wall_map_receiver against an array model of the wall map.
module tb_wall_map_receiver;

    localparam int unsigned ADDR_W      = 8;
    localparam int unsigned DATA_W      = 8;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DEPTH       = 2 ** ADDR_W;

    logic              Clk;
    logic              Reset;
    logic [ADDR_W-1:0] walls_addr;
    logic [DATA_W-1:0] walls_data;
    logic              walls_we;
    logic              clear_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              screen_reset;
`ifdef WALL_MAP_ECHO_EN
    logic [DATA_W-1:0] echo_data;
`endif

    wall_map_receiver #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .SYNC_STAGES(SYNC_STAGES),
        .CLEAR_VAL  (8'h00)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .walls_addr  (walls_addr),
        .walls_data  (walls_data),
        .walls_we    (walls_we),
        .clear_req   (clear_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .busy        (busy),
        .screen_reset(screen_reset)
`ifdef WALL_MAP_ECHO_EN
        ,
        .echo_data   (echo_data)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          vectors = 0;
    int          errors  = 0;
    logic [7:0]  model [DEPTH];
    bit          known [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Full write handshake as software would issue it: set bus, raise strobe, hold, drop.
    task automatic write_word(input logic [7:0] a, input logic [7:0] d);
        walls_addr = a;
        walls_data = d;
        tick();
        walls_we = 1'b1;
        repeat (SYNC_STAGES + 4) tick();
        walls_we = 1'b0;
        repeat (SYNC_STAGES + 2) tick();
        model[a] = d;
        known[a] = 1'b1;
    endtask

    task automatic read_check(input logic [7:0] a);
        rd_addr    = a;
        walls_addr = a;
        tick();
        if (known[a]) begin
            check($sformatf("rd[%0h]", a), 32'(rd_data), 32'(model[a]));
`ifdef WALL_MAP_ECHO_EN
            check($sformatf("echo[%0h]", a), 32'(echo_data), 32'(model[a]));
`endif
        end
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) read_check(8'(i));
    endtask

    task automatic pulse_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 600) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 8'h00;
            known[i] = 1'b1;
        end
    endtask

    initial begin
        int sr_cnt;
        int bsy_cnt;
        logic [7:0] ra;
        logic [7:0] rdd;

        for (int i = 0; i < DEPTH; i++) begin
            model[i] = 8'h00;
            known[i] = 1'b0;
        end
        Reset      = 1'b1;
        walls_addr = '0;
        walls_data = '0;
        walls_we   = 1'b0;
        clear_req  = 1'b0;
        rd_addr    = '0;
        repeat (2) tick();
        Reset = 1'b0;
        tick();
        check("rst_rd_data", 32'(rd_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_screen_reset", 32'(screen_reset), 32'(0));

        // Write latency: visible SYNC_STAGES+3 cycles after the strobe rises; busy only for the WRITE cycle.
        rd_addr    = 8'h05;
        walls_addr = 8'h05;
        walls_data = 8'hA3;
        tick();
        walls_we = 1'b1;
        for (int i = 1; i <= SYNC_STAGES + 3; i++) begin
            tick();
            check($sformatf("lat_busy_c%0d", i), 32'(busy), 32'(i == SYNC_STAGES + 1));
        end
        check("lat_rd_data", 32'(rd_data), 32'(8'hA3));
        walls_we = 1'b0;
        repeat (SYNC_STAGES + 2) tick();
        model[5] = 8'hA3;
        known[5] = 1'b1;

        // Held strobe yields one write; data change while still high is ignored.
        walls_addr = 8'h10;
        walls_data = 8'h01;
        tick();
        walls_we = 1'b1;
        repeat (20) tick();
        walls_data = 8'h02;
        repeat (10) tick();
        walls_we = 1'b0;
        repeat (SYNC_STAGES + 2) tick();
        model[8'h10] = 8'h01;
        known[8'h10] = 1'b1;
        read_check(8'h10);

        // Random writes, including repeats to a small address pool, then random reads.
        for (int i = 0; i < 40; i++) begin
            ra  = ((i % 3) == 0) ? 8'($urandom_range(32, 39)) : 8'($urandom);
            rdd = 8'($urandom);
            write_word(ra, rdd);
        end
        for (int i = 0; i < 40; i++) read_check(8'($urandom_range(32, 39)));
        for (int i = 0; i < 20; i++) read_check(8'($urandom));

        // Fill with FF, clear, measure screen_reset/busy widths and masked read data.
        for (int i = 0; i < DEPTH; i++) write_word(8'(i), 8'hFF);
        read_check(8'h80);
        sr_cnt  = 0;
        bsy_cnt = 0;
        clear_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rd_addr = 8'($urandom);
            tick();
            if (i == 0) clear_req = 1'b0;
            sr_cnt  += int'(screen_reset);
            bsy_cnt += int'(busy);
            if (screen_reset) check("clear_rd_mask", 32'(rd_data), 32'(0));
        end
        check("clear_sr_cycles", 32'(sr_cnt), 32'(DEPTH));
        check("clear_busy_cycles", 32'(bsy_cnt), 32'(DEPTH + 1));
        model_clear();
        read_all();

        // Write arriving mid-sweep survives the clear.
        pulse_clear();
        repeat (10) tick();
        walls_addr = 8'h02;
        walls_data = 8'h7E;
        walls_we   = 1'b1;
        repeat (SYNC_STAGES + 4) tick();
        walls_we = 1'b0;
        check("sweep_sr_high", 32'(screen_reset), 32'(1));
        wait_idle();
        model_clear();
        model[8'h02] = 8'h7E;
        read_all();

        // Clear request coincident with a write edge: clear first, write after.
        walls_addr = 8'h40;
        walls_data = 8'h11;
        tick();
        walls_we = 1'b1;
        repeat (SYNC_STAGES) tick();
        pulse_clear();
        check("coinc_sr", 32'(screen_reset), 32'(1));
        repeat (4) tick();
        walls_we = 1'b0;
        wait_idle();
        model_clear();
        model[8'h40] = 8'h11;
        read_all();

        // Reset in the middle of a sweep: partial clear, pending write discarded.
        for (int i = 0; i < DEPTH; i++) write_word(8'(i), 8'($urandom_range(1, 255)));
        pulse_clear();
        repeat (50) tick();
        walls_addr = 8'd200;
        walls_data = 8'h5A;
        walls_we   = 1'b1;
        repeat (5) tick();
        walls_we = 1'b0;
        repeat (45) tick();
        check("mid_busy", 32'(busy), 32'(1));
        check("mid_sr", 32'(screen_reset), 32'(1));
        Reset = 1'b1;
        #1;
        check("async_busy", 32'(busy), 32'(0));
        check("async_sr", 32'(screen_reset), 32'(0));
        check("async_rd", 32'(rd_data), 32'(0));
        repeat (2) tick();
        Reset = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'(0));
        for (int i = 0; i < 100; i++) model[i] = 8'h00;
        read_all();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
